// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared SHA-256 definitions for the iterative compression core:
//   word / state / schedule typedefs, the 64-entry round constant table K,
//   the standard initial hash value H0, the core FSM state type and the
//   bitwise round primitives (ROTR, big sigma 0/1, Ch, Maj).
package sha256_pkg;

   typedef logic [31:0]       word;
   typedef logic [0:7][31:0]  state8;
   typedef logic [0:63][31:0] sched64;

   typedef enum logic [1:0] {
      ST_ROUND = 2'd0,
      ST_FINAL = 2'd1,
      ST_DONE  = 2'd2
   } core_state_e;

   // Round constants; K[0] is the leftmost entry of the concatenation.
   localparam sched64 K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam state8 H0 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word rotr(input word x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word big_sigma0(input word x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word big_sigma1(input word x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word ch(input word e, input word f, input word g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word maj(input word a, input word b, input word c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_iter_compress_if.sv
// sha256_iter_compress_if
//   Data bundle between the compression core and its user.
//   H_in  : chaining value, word 0 = a               (user -> core)
//   W     : pre-expanded 64-word message schedule    (user -> core)
//   H_out : digest, word i in bits [i*32 +: 32]      (core -> user)
//   done  : digest valid, sticky until reset         (core -> user)
//   test  : debug tap, new "a" of the current round  (core -> user)
interface sha256_iter_compress_if;
   import sha256_pkg::*;

   state8        H_in;
   sched64       W;
   logic [0:255] H_out;
   logic         done;
   word          test;

   modport master (output H_in, output W, input H_out, input done, input test);
   modport slave  (input H_in, input W, output H_out, output done, output test);

endinterface

// File: rtl/sha256_round.sv
// sha256_round
//   Purely combinational single SHA-256 round.
//   v_in  : working variables a..h (index 0 = a)
//   kt    : round constant K[t]
//   wt    : message schedule word W[t]
//   v_out : working variables after the round (index 0 = new a = T1+T2)
module sha256_round
   import sha256_pkg::*;
(
   input  state8 v_in,
   input  word   kt,
   input  word   wt,
   output state8 v_out
);

   word t1;
   word t2;

   always_comb begin
      t1 = v_in[7] + big_sigma1(v_in[4]) + ch(v_in[4], v_in[5], v_in[6]) + kt + wt;
      t2 = big_sigma0(v_in[0]) + maj(v_in[0], v_in[1], v_in[2]);
      v_out = {t1 + t2, v_in[0], v_in[1], v_in[2],
               v_in[3] + t1, v_in[4], v_in[5], v_in[6]};
   end

endmodule

// File: rtl/sha256_iter_compress.sv
// sha256_iter_compress
//   Iterative SHA-256 compression: one round per clock, 64 rounds, then one
//   cycle adding the latched chaining value to produce the digest.
//   clk   : rising-edge clock
//   reset : synchronous active-high; loads a..h and the base copy from
//           H_in, clears H_out/done and restarts at round 0
//   bus   : slave side of sha256_iter_compress_if (H_in, W in; H_out,
//           done, test out)
//   Build option: define SHA_DEBUG_TAP_EN to drive bus.test with the
//   current round's new "a"; otherwise bus.test is tied to zero.
module sha256_iter_compress
   import sha256_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   sha256_iter_compress_if.slave  bus
);

   core_state_e  st_q,    st_d;
   logic [5:0]   cnt_q,   cnt_d;
   state8        vars_q,  vars_d;
   state8        hbase_q, hbase_d;
   logic [0:255] hout_q,  hout_d;
   logic         done_q,  done_d;
   state8        round_out;

   // Round datapath: fed from the live schedule word at the current index.
   // After round 63 the index stays at 63, so the round output (and the
   // debug tap) remains a deterministic function of the held variables.
   sha256_round u_round (
      .v_in  (vars_q),
      .kt    (K[cnt_q]),
      .wt    (bus.W[cnt_q]),
      .v_out (round_out)
   );

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      vars_d  = vars_q;
      hbase_d = hbase_q;
      hout_d  = hout_q;
      done_d  = done_q;
      case (st_q)
         ST_ROUND: begin
            vars_d = round_out;
            if (cnt_q == 6'd63) begin
               st_d = ST_FINAL;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_FINAL: begin
            for (int i = 0; i < 8; i++) begin
               hout_d[i*32 +: 32] = hbase_q[i] + vars_q[i];
            end
            done_d = 1'b1;
            st_d   = ST_DONE;
         end
         ST_DONE: begin
            st_d = ST_DONE;
         end
         default: begin
            st_d = ST_DONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= ST_ROUND;
         cnt_q   <= 6'd0;
         vars_q  <= bus.H_in;
         hbase_q <= bus.H_in;
         hout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         vars_q  <= vars_d;
         hbase_q <= hbase_d;
         hout_q  <= hout_d;
         done_q  <= done_d;
      end
   end

   assign bus.H_out = hout_q;
   assign bus.done  = done_q;

`ifdef SHA_DEBUG_TAP_EN
   assign bus.test = round_out[0];
`else
   assign bus.test = 32'h0;
`endif

endmodule

// File: tb/tb_sha256_iter_compress.sv
// tb_sha256_iter_compress
//   Directed + randomized bench for sha256_iter_compress. Expected digests
//   come from published SHA-256 vectors or from a loop-based reference
//   compression function inside the bench. Honors SHA_DEBUG_TAP_EN.
module tb_sha256_iter_compress;
   import sha256_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sha256_iter_compress_if bus ();

   sha256_iter_compress dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [0:255] DIG_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [0:255] DIG_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic [0:7][31:0] iv;
   bit   [31:0]      ref_a [64];

   function automatic bit [31:0] rr(input bit [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Standard message schedule expansion of a 16-word block.
   function automatic logic [0:63][31:0] expand(input logic [0:15][31:0] m);
      logic [0:63][31:0] w;
      bit [31:0] s0, s1;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            w[t] = m[t];
         end else begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
         end
      end
      return w;
   endfunction

   // Reference compression; also records each round's new "a" in ref_a.
   function automatic logic [0:255] ref_compress(input logic [0:7][31:0] h,
                                                 input logic [0:63][31:0] w);
      bit [31:0] v [8];
      bit [31:0] t1, t2, s0, s1, chv, mjv;
      logic [0:255] d;
      for (int i = 0; i < 8; i++) v[i] = h[i];
      for (int t = 0; t < 64; t++) begin
         s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
         chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
         t1  = v[7] + s1 + chv + K[t] + w[t];
         s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
         mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
         t2  = s0 + mjv;
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
         ref_a[t] = v[0];
      end
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = h[i] + v[i];
      return d;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Loads H_in/W with reset high across one rising edge.
   task automatic setup(input logic [0:7][31:0] h, input logic [0:63][31:0] w,
                        output logic [0:255] golden);
      reset    = 1'b1;
      bus.H_in = h;
      bus.W    = w;
      golden   = ref_compress(h, w);
      @(negedge clk);
   endtask

   // Releases reset and watches the run; H_in is scrambled after release.
   task automatic run_block(input string tag, input logic [0:255] exp);
      int lat;
      lat = 0;
      reset    = 1'b0;
      bus.H_in = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
`ifndef SHA_DEBUG_TAP_EN
      chk({tag, "_test_zero"}, bus.test, 32'h0);
`endif
      for (int i = 1; i <= 70; i++) begin
`ifdef SHA_DEBUG_TAP_EN
         if (i <= 64) chk($sformatf("%s_tap%0d", tag, i - 1), bus.test, ref_a[i-1]);
`endif
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_done_edge"}, lat, 65);
      chk({tag, "_digest"}, bus.H_out, exp);
   endtask

   initial begin
      logic [0:15][31:0] m;
      logic [0:63][31:0] w_abc;
      logic [0:63][31:0] w_rnd;
      logic [0:7][31:0]  h_rnd;
      logic [0:255]      gold;

      checks = 0;
      errors = 0;
      iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      m = '0; m[0] = 32'h61626380; m[15] = 32'h00000018;
      w_abc = expand(m);

      // Reset state
      reset = 1'b1;
      bus.H_in = iv;
      bus.W = w_abc;
      @(negedge clk);
      @(negedge clk);
      chk("reset_done", bus.done, 1'b0);
      chk("reset_hout", bus.H_out, 256'h0);
`ifdef SHA_DEBUG_TAP_EN
      chk("abc_round0_tap", bus.test, 32'h5d6aebcd);
`endif

      // "abc"
      setup(iv, w_abc, gold);
      run_block("abc", DIG_ABC);

      // Sticky done while W is disturbed, then reset from DONE
      bus.W = {64{$urandom}};
      repeat (200) @(negedge clk);
      chk("sticky_done", bus.done, 1'b1);
      chk("sticky_hout", bus.H_out, DIG_ABC);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_from_done_done", bus.done, 1'b0);
      chk("rst_from_done_hout", bus.H_out, 256'h0);

      // Bytes 87 02 79 against the reference
      m = '0; m[0] = 32'h87027980; m[15] = 32'h00000018;
      setup(iv, expand(m), gold);
      run_block("b870279", gold);

      // Empty message
      m = '0; m[0] = 32'h80000000;
      setup(iv, expand(m), gold);
      run_block("empty", DIG_EMPTY);

      // Abort at edge 30 then rerun "abc"
      setup(iv, w_abc, gold);
      reset = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_done", bus.done, 1'b0);
`ifdef SHA_DEBUG_TAP_EN
      chk("abort_tap", bus.test, 32'h5d6aebcd);
`endif
      run_block("abc_rerun", DIG_ABC);

      // Random chaining values and schedules
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) h_rnd[i] = $urandom;
         for (int i = 0; i < 64; i++) w_rnd[i] = $urandom;
         setup(h_rnd, w_rnd, gold);
         run_block($sformatf("rand%0d", r), gold);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
